seq_div_2n_by_n: RTL and testbench

- Sequential radix-2 restoring divider, the inverse of the 16x16 Karatsuba multiplier.
- Takes a 2N-bit product P and an N-bit factor B, and returns Q = P / B and R = P % B.
- Used to recover the other operand, and to score the approximate multiplier's outputs against exact arithmetic in the error-analysis flow.
- Has a valid/ready handshake on both its input and output, and processes one quotient bit per cycle.

---
 rtl/seq_div_2n_by_n.sv | 171 +++++++++++++++++
 tb/tb_seq_div_2n_by_n.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_2n_by_n.sv
// seq_div_2n_by_n: sequential radix-2 restoring divider.
// Divides a 2N-bit unsigned dividend P by an N-bit unsigned divisor B and
// returns an N-bit quotient Q and remainder R, one quotient bit per cycle.
// Divide-by-zero and quotient overflow are detected up front and answered
// in a single cycle. Valid/ready handshakes on both input and output.
module seq_div_2n_by_n #(
   parameter int N = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] P,
   input  logic [N-1:0]   B,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   Q,
   output logic [N-1:0]   R,
   output logic           div_zero,
   output logic           ovf
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_r, state_s;
   logic [N-1:0]   b_r, b_s;
   // The partial remainder is always strictly below the divisor, so its
   // top bit is structurally zero and is not stored; the trial value below
   // re-extends it to N+1 bits for the compare.
   logic [N-1:0]   pr_r, pr_s;
   // Low dividend half shifts out MSB-first while quotient bits shift in at
   // the LSB, so after N iterations this register holds the quotient.
   logic [N-1:0]   low_r, low_s;
   logic [CW-1:0]  cnt_r, cnt_s;
   logic           out_valid_r, out_valid_s;
   logic [N-1:0]   q_r, q_s;
   logic [N-1:0]   r_r, r_s;
   logic           dz_r, dz_s;
   logic           ovf_r, ovf_s;

   logic [N:0]     t_s;
   logic           ge_s;
   logic [N-1:0]   diff_s;
   logic [N-1:0]   pr_step_s;
   logic [N-1:0]   low_step_s;

   // One restoring step: form the trial value, compare, conditionally subtract.
   always_comb begin
      t_s    = {pr_r, low_r[N-1]};
      ge_s   = (t_s >= {1'b0, b_r});
      // When T >= B the difference is below B, so N bits hold it exactly.
      diff_s = t_s[N-1:0] - b_r;
      if (ge_s) begin
         pr_step_s = diff_s;
      end else begin
         pr_step_s = t_s[N-1:0];
      end
      low_step_s = {low_r[N-2:0], ge_s};
   end

   // Next-state and next-datapath decode for the IDLE/RUN/DONE controller.
   always_comb begin
      state_s     = state_r;
      b_s         = b_r;
      pr_s        = pr_r;
      low_s       = low_r;
      cnt_s       = cnt_r;
      out_valid_s = out_valid_r;
      q_s         = q_r;
      r_s         = r_r;
      dz_s        = dz_r;
      ovf_s       = ovf_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               b_s = B;
               if (B == {N{1'b0}}) begin
                  state_s     = DONE;
                  out_valid_s = 1'b1;
                  q_s         = {N{1'b1}};
                  r_s         = P[N-1:0];
                  dz_s        = 1'b1;
                  ovf_s       = 1'b0;
               end else if (P[2*N-1:N] >= B) begin
                  state_s     = DONE;
                  out_valid_s = 1'b1;
                  q_s         = {N{1'b1}};
                  r_s         = {N{1'b0}};
                  dz_s        = 1'b0;
                  ovf_s       = 1'b1;
               end else begin
                  state_s = RUN;
                  pr_s    = P[2*N-1:N];
                  low_s   = P[N-1:0];
                  cnt_s   = CW'(N);
               end
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            pr_s  = pr_step_s;
            low_s = low_step_s;
            cnt_s = cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
               state_s     = DONE;
               out_valid_s = 1'b1;
               q_s         = low_step_s;
               r_s         = pr_step_s;
               dz_s        = 1'b0;
               ovf_s       = 1'b0;
            end else begin
               state_s = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_s     = IDLE;
               out_valid_s = 1'b0;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s     = IDLE;
            out_valid_s = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         b_r         <= {N{1'b0}};
         pr_r        <= {N{1'b0}};
         low_r       <= {N{1'b0}};
         cnt_r       <= {CW{1'b0}};
         out_valid_r <= 1'b0;
         q_r         <= {N{1'b0}};
         r_r         <= {N{1'b0}};
         dz_r        <= 1'b0;
         ovf_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         b_r         <= b_s;
         pr_r        <= pr_s;
         low_r       <= low_s;
         cnt_r       <= cnt_s;
         out_valid_r <= out_valid_s;
         q_r         <= q_s;
         r_r         <= r_s;
         dz_r        <= dz_s;
         ovf_r       <= ovf_s;
      end
   end

   assign in_ready  = (state_r == IDLE);
   assign out_valid = out_valid_r;
   assign Q         = q_r;
   assign R         = r_r;
   assign div_zero  = dz_r;
   assign ovf       = ovf_r;

endmodule

// File: tb/tb_seq_div_2n_by_n.sv
// Self-checking bench for seq_div_2n_by_n (N=16): directed vectors with
// literal expectations plus an arithmetic reference model checked each cycle.
module tb_seq_div_2n_by_n;

   localparam int N    = 16;
   localparam int NOPS = 2000;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   P;
   logic [15:0]   B;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   Q;
   logic [15:0]   R;
   logic          div_zero;
   logic          ovf;

   int tests = 0;
   int fails = 0;

   seq_div_2n_by_n #(.N(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .P(P), .B(B), .out_valid(out_valid), .out_ready(out_ready),
      .Q(Q), .R(R), .div_zero(div_zero), .ovf(ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] p;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      logic        ov;
      int          vis;
   } op_t;

   op_t exp_q[$];
   bit  busy = 1'b0;
   bit  live = 1'b0;
   int  cyc  = 0;
   int  done_cnt = 0;

   function automatic op_t model(input logic [31:0] p, input logic [15:0] b, input int now);
      op_t e;
      e.p = p; e.b = b; e.dz = 1'b0; e.ov = 1'b0;
      if (b == 16'd0) begin
         e.dz = 1'b1; e.q = 16'hFFFF; e.r = p[15:0]; e.vis = now + 1;
      end else if ((p / 32'h10000) >= {16'd0, b}) begin
         e.ov = 1'b1; e.q = 16'hFFFF; e.r = 16'd0; e.vis = now + 1;
      end else begin
         e.q = 16'(p / {16'd0, b});
         e.r = 16'(p % {16'd0, b});
         e.vis = now + 1 + N;
      end
      return e;
   endfunction

   // Per-cycle comparison of handshake and result outputs against the model.
   always @(negedge clk) begin
      logic  exp_ov;
      logic [63:0] rec;
      cyc++;
      if (live) begin
         check("in_ready", {63'd0, in_ready}, {63'd0, !busy});
         exp_ov = busy && (exp_q.size() > 0) && (cyc >= exp_q[0].vis);
         check("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
         if (exp_ov && out_valid) begin
            check("model_q", {48'd0, Q}, {48'd0, exp_q[0].q});
            check("model_r", {48'd0, R}, {48'd0, exp_q[0].r});
            check("model_dz", {63'd0, div_zero}, {63'd0, exp_q[0].dz});
            check("model_ovf", {63'd0, ovf}, {63'd0, exp_q[0].ov});
            if (!exp_q[0].dz && !exp_q[0].ov) begin
               rec = 64'(Q) * 64'(exp_q[0].b) + 64'(R);
               check("inv_qb_plus_r", rec, 64'(exp_q[0].p));
               check("inv_r_lt_b", {63'd0, (R < exp_q[0].b)}, 64'd1);
            end
         end
      end
      if (rst) begin
         exp_q.delete();
         busy = 1'b0;
         live = 1'b1;
      end else if (live) begin
         if (busy && out_valid && out_ready && exp_q.size() > 0 && cyc >= exp_q[0].vis) begin
            void'(exp_q.pop_front());
            busy = 1'b0;
            done_cnt++;
         end else if (!busy && in_valid) begin
            exp_q.push_back(model(P, B, cyc));
            busy = 1'b1;
         end
      end
   end

   // ---------------- directed driver ----------------
   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("wait_in_ready", {63'd0, in_ready}, 64'd1);
   endtask

   task automatic run_op(input logic [31:0] p, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic edz, input logic eov, input int hold);
      int n = 0;
      wait_ready();
      in_valid = 1'b1; P = p; B = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      while (!out_valid && n < 3 * N) begin
         @(posedge clk); #1;
         n++;
      end
      check("lit_latency", 64'(n), (edz || eov) ? 64'd0 : 64'(N));
      check("lit_q", {48'd0, Q}, {48'd0, eq});
      check("lit_r", {48'd0, R}, {48'd0, er});
      check("lit_dz", {63'd0, div_zero}, {63'd0, edz});
      check("lit_ovf", {63'd0, ovf}, {63'd0, eov});
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", {63'd0, out_valid}, 64'd1);
         check("hold_q", {48'd0, Q}, {48'd0, eq});
         check("hold_r", {48'd0, R}, {48'd0, er});
         check("hold_flags", {62'd0, div_zero, ovf}, {62'd0, edz, eov});
         check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("drain_valid", {63'd0, out_valid}, 64'd0);
      check("drain_in_ready", {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      logic        acc;
      int          sent;
      int          start;
      logic [15:0] bh;
      logic [15:0] ah;
      logic [15:0] hi;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; P = 32'd0; B = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_qr", {32'd0, Q, R}, 64'd0);
      check("rst_flags", {62'd0, div_zero, ovf}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Exact, remainder and extreme operands; exceptions.
      run_op(32'h000493E0, 16'h012C, 16'h03E8, 16'h0000, 1'b0, 1'b0, 0);
      run_op(32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0);
      run_op(32'h0000FFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0);
      run_op(32'h00010000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 0);
      run_op(32'h12345678, 16'h0000, 16'hFFFF, 16'h5678, 1'b1, 1'b0, 0);
      run_op(32'h0000FFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 2);

      // Backpressure with junk operands toggled on the input during RUN.
      wait_ready();
      in_valid = 1'b1; P = 32'h000493E7; B = 16'h012C;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         P = $urandom;
         B = 16'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      begin
         int n = 0;
         while (!out_valid && n < 3 * N) begin
            @(posedge clk); #1;
            n++;
         end
      end
      check("bp_q", {48'd0, Q}, 64'h03E8);
      check("bp_r", {48'd0, R}, 64'h0007);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_hold", {31'd0, out_valid, Q, R}, {31'd0, 1'b1, 16'h03E8, 16'h0007});
         check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_drain_valid", {63'd0, out_valid}, 64'd0);
      check("bp_drain_ready", {63'd0, in_ready}, 64'd1);

      // Reset seven cycles into RUN, then a clean operation.
      in_valid = 1'b1; P = 32'h000493E0; B = 16'h012C;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("mid_rst_outputs", {30'd0, Q, R, div_zero, ovf}, 64'd0);
      run_op(32'h000493E0, 16'h012C, 16'h03E8, 16'h0000, 1'b0, 1'b0, 0);

      // Exact products: dividing AH*BH by BH must return AH.
      for (int i = 0; i < 16; i++) begin
         ah = 16'($urandom);
         bh = 16'($urandom_range(65535, 1));
         run_op(32'(ah) * 32'(bh), bh, ah, 16'd0, 1'b0, 1'b0, 0);
      end

      // Random back-to-back regression with throttled consumer.
      start = done_cnt;
      sent = 0;
      bh = 16'($urandom_range(65535, 1));
      hi = 16'($urandom % 32'(bh));
      B = bh; P = {hi, 16'($urandom)};
      in_valid = 1'b1;
      for (int c = 0; c < 60000 && (done_cnt - start) < NOPS; c++) begin
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin
            sent++;
            if (sent < NOPS) begin
               bh = 16'($urandom_range(65535, 1));
               hi = 16'($urandom % 32'(bh));
               B = bh; P = {hi, 16'($urandom)};
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(3, 0) != 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("random_completed", 64'(done_cnt - start), 64'(NOPS));

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
